seq_divider: RTL

- Multi-cycle restoring divider for the stack-CPU ALU. It is the inverse-operation counterpart of the carry-lookahead adder path: it consumes operands and produces a quotient and remainder by iterated subtract-and-test.
- Handles signed and unsigned DIV/MOD opcodes that the single-cycle adder datapath cannot.
- Sits beside the adder in the ALU. The control unit starts it and stalls on busy until done.

---
 rtl/seq_divider.sv | 124 ++++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// Restoring divider (signed/unsigned DIV/MOD); WIDTH+2 cycles accept-to-done, 1 cycle on divide-by-zero.
// No backpressure: start is accepted only in IDLE, is ignored otherwise, and results hold until the next accept.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] divisor_mag;
    logic [CNT_W-1:0] cnt;
    logic             sign_q;
    logic             sign_r;

    logic [WIDTH-1:0] dividend_mag_in;
    logic [WIDTH-1:0] divisor_mag_in;
    logic [WIDTH:0]   rem_shifted;
    logic [WIDTH:0]   trial;

    assign dividend_mag_in = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
    assign divisor_mag_in  = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;

    // The shifted partial remainder needs WIDTH+1 bits; trial's MSB is the borrow.
    assign rem_shifted = {part_rem, quo_shift[WIDTH-1]};
    assign trial       = rem_shifted - {1'b0, divisor_mag};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            part_rem    <= '0;
            quo_shift   <= '0;
            divisor_mag <= '0;
            cnt         <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign_q      <= signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        sign_r      <= signed_op & dividend[WIDTH-1];
                        quo_shift   <= dividend_mag_in;
                        divisor_mag <= divisor_mag_in;
                        part_rem    <= '0;
                        cnt         <= CNT_W'(WIDTH);
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    // Dividend bits shift out of the top while quotient bits fill in at the bottom.
                    part_rem  <= trial[WIDTH] ? rem_shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    quo_shift <= {quo_shift[WIDTH-2:0], ~trial[WIDTH]};
                    cnt       <= cnt - CNT_W'(1);
                end
                FIX: begin
                    quotient  <= sign_q ? -quo_shift : quo_shift;
                    remainder <= sign_r ? -part_rem  : part_rem;
                end
                default: ;
            endcase
        end
    end

endmodule
